// File: rtl/enemy_fire_scheduler_pkg.sv
// Shared definitions for the enemy fire scheduling logic (package galaga_lib).
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
// Contents: default enemy/projectile counts, screen bottom limit, fire FSM state
// type, and rr_pick(), a reference round-robin pick for the default enemy count.
package galaga_lib;

  localparam int NE_DEFAULT   = 8;
  localparam int NP_E_DEFAULT = 4;
  localparam int SCREEN_H_MAX = 479;
  localparam int NE_IDX_W     = $clog2(NE_DEFAULT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    COOL = 2'd2
  } fire_state_t;

  // First set bit of req scanning ptr, ptr+1, ... with wrap. NE_DEFAULT is a
  // power of two, so the index addition wraps on its own. Scanning downward
  // lets the smallest offset from ptr overwrite any larger one.
  function automatic logic [NE_IDX_W-1:0] rr_pick(input logic [NE_DEFAULT-1:0] req,
                                                  input logic [NE_IDX_W-1:0]   ptr);
    logic [NE_IDX_W-1:0] idx;
    rr_pick = ptr;
    for (int i = NE_DEFAULT - 1; i >= 0; i--) begin
      idx = ptr + NE_IDX_W'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/enemy_fire_scheduler_rr_arbiter_ne.sv
// Round-robin winner pick over NE requesters: rotate by ptr, priority-encode, unrotate.
// Latency: purely combinational.
// Backpressure: none; winVld simply reports that some request is set.
// Ports: req (NE request bits), ptr (scan start index), winIdx (winner), winVld (any request).
module rr_arbiter_ne import galaga_lib::*; #(
  parameter int NE = NE_DEFAULT
) (
  input  logic [NE-1:0]         req,
  input  logic [$clog2(NE)-1:0] ptr,
  output logic [$clog2(NE)-1:0] winIdx,
  output logic                  winVld
);

  localparam int IW = $clog2(NE);
  localparam logic [IW:0] NE_V = (IW+1)'(NE);

  logic [NE-1:0] rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;

  always_comb begin
    // Bit 0 of rot corresponds to requester ptr.
    rot = NE'({req, req} >> ptr);
    off = '0;
    for (int i = NE - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
    // Unrotate with an explicit modulo so non-power-of-two NE also works.
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NE_V) sum = sum - NE_V;
  end

  assign winIdx = sum[IW-1:0];
  assign winVld = |req;

endmodule

// File: rtl/enemy_fire_scheduler.sv
// Picks which enemy fires next and which free projectile slot the shot occupies.
// Latency: inputs sampled on one frame_clk edge produce a one-cycle launch on the next.
// Backpressure: no launch while every slot is busy; launches spaced by COOLDOWN+1 frames.
// Ports: frame_clk/Reset (async active-low); game_active, fire_req, enemy_alive,
//   enemy_x/enemy_y (10 bits per enemy, enemy i at [10i+9:10i]), slot_busy, ship_x in;
//   grant (one-hot), launch, launch_slot, launch_x, launch_y, launch_dir out (registered).
// Build option: define FIRE_AIM_EN to steer launch_dir toward ship_x; otherwise it is 0.
module enemy_fire_scheduler import galaga_lib::*; #(
  parameter int NE       = NE_DEFAULT,
  parameter int NP       = NP_E_DEFAULT,
  parameter int COOLDOWN = 16,
  parameter int SPAWN_DY = 12
) (
  input  logic                  frame_clk,
  input  logic                  Reset,
  input  logic                  game_active,
  input  logic [NE-1:0]         fire_req,
  input  logic [NE-1:0]         enemy_alive,
  input  logic [NE*10-1:0]      enemy_x,
  input  logic [NE*10-1:0]      enemy_y,
  input  logic [NP-1:0]         slot_busy,
  input  logic [9:0]            ship_x,
  output logic [NE-1:0]         grant,
  output logic                  launch,
  output logic [$clog2(NP)-1:0] launch_slot,
  output logic [9:0]            launch_x,
  output logic [9:0]            launch_y,
  output logic [1:0]            launch_dir
);

  localparam int IW = $clog2(NE);
  localparam int SW = $clog2(NP);

  fire_state_t   state, nextState;
  logic [IW-1:0] rrPtr, nextRrPtr;
  logic [7:0]    coolCnt, nextCoolCnt;
  logic          fire;

  logic [NE-1:0] elig;
  logic [IW-1:0] winIdx;
  logic          winVld;
  logic [SW-1:0] freeSlot;
  logic          slotVld;
  logic [9:0]    winX, winY;
  logic [10:0]   spawnY;
  logic [9:0]    spawnYSat;
  logic [1:0]    aimDir;

  assign elig = fire_req & enemy_alive;

  rr_arbiter_ne #(.NE(NE)) uArb (
    .req    (elig),
    .ptr    (rrPtr),
    .winIdx (winIdx),
    .winVld (winVld)
  );

  // Lowest-index free slot.
  always_comb begin
    freeSlot = '0;
    for (int i = NP - 1; i >= 0; i--) begin
      if (!slot_busy[i]) freeSlot = SW'(i);
    end
  end
  assign slotVld = ~&slot_busy;

  assign winX = enemy_x[int'(winIdx)*10 +: 10];
  assign winY = enemy_y[int'(winIdx)*10 +: 10];

  // Spawn point can fall below the playfield; clamp to the last visible row.
  assign spawnY    = {1'b0, winY} + 11'(SPAWN_DY);
  assign spawnYSat = (spawnY > 11'(SCREEN_H_MAX)) ? 10'(SCREEN_H_MAX) : spawnY[9:0];

`ifdef FIRE_AIM_EN
  // An 8-pixel dead zone either side of the enemy keeps straight-down shots
  // when the ship is roughly underneath. 11-bit compares avoid wrap at 1023.
  always_comb begin
    aimDir = 2'b00;
    if ({1'b0, ship_x} > {1'b0, winX} + 11'd8)
      aimDir = 2'b01;
    else if ({1'b0, ship_x} + 11'd8 < {1'b0, winX})
      aimDir = 2'b11;
  end
`else
  assign aimDir = 2'b00;
  logic unusedShipX;
  assign unusedShipX = ^ship_x;
`endif

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      rrPtr   <= '0;
      coolCnt <= '0;
    end else begin
      state   <= nextState;
      rrPtr   <= nextRrPtr;
      coolCnt <= nextCoolCnt;
    end
  end

  always_comb begin
    nextState   = state;
    nextRrPtr   = rrPtr;
    nextCoolCnt = coolCnt;
    fire        = 1'b0;
    case (state)
      IDLE: begin
        nextCoolCnt = '0;
        if (game_active) nextState = ARB;
      end
      ARB: begin
        if (!game_active) begin
          nextState   = IDLE;
          nextCoolCnt = '0;
        end else if (winVld && slotVld) begin
          fire        = 1'b1;
          nextRrPtr   = (winIdx == IW'(NE - 1)) ? '0 : winIdx + 1'b1;
          nextCoolCnt = 8'(COOLDOWN);
          nextState   = COOL;
        end
      end
      COOL: begin
        if (!game_active) begin
          nextState   = IDLE;
          nextCoolCnt = '0;
        end else begin
          nextCoolCnt = coolCnt - 8'd1;
          if (coolCnt == 8'd1) nextState = ARB;
        end
      end
      default: begin
        nextState   = IDLE;
        nextCoolCnt = '0;
      end
    endcase
  end

  // Strobes clear after one cycle; slot/position hold their last launch values.
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      grant       <= '0;
      launch      <= 1'b0;
      launch_slot <= '0;
      launch_x    <= '0;
      launch_y    <= '0;
      launch_dir  <= 2'b00;
    end else begin
      launch     <= fire;
      grant      <= fire ? (NE'(1) << winIdx) : '0;
      launch_dir <= fire ? aimDir : 2'b00;
      if (fire) begin
        launch_slot <= freeSlot;
        launch_x    <= winX;
        launch_y    <= spawnYSat;
      end
    end
  end

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Self-checking bench for enemy_fire_scheduler (COOLDOWN=4).
// Latency: n/a.  Backpressure: n/a.
// Stimulus pushes expected launches (cycle, grant, slot, x, y, dir) into a queue;
// a negedge monitor pops and compares whenever launch is high.
module tb_enemy_fire_scheduler;

  localparam int NE = 8;
  localparam int NP = 4;
  localparam int CD = 4;
  localparam int DY = 12;

  logic           frame_clk = 1'b0;
  logic           Reset;
  logic           game_active;
  logic [NE-1:0]  fire_req;
  logic [NE-1:0]  enemy_alive;
  logic [NE*10-1:0] enemy_x;
  logic [NE*10-1:0] enemy_y;
  logic [NP-1:0]  slot_busy;
  logic [9:0]     ship_x;
  logic [NE-1:0]  grant;
  logic           launch;
  logic [1:0]     launch_slot;
  logic [9:0]     launch_x;
  logic [9:0]     launch_y;
  logic [1:0]     launch_dir;

  enemy_fire_scheduler #(.NE(NE), .NP(NP), .COOLDOWN(CD), .SPAWN_DY(DY)) dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .game_active (game_active),
    .fire_req    (fire_req),
    .enemy_alive (enemy_alive),
    .enemy_x     (enemy_x),
    .enemy_y     (enemy_y),
    .slot_busy   (slot_busy),
    .ship_x      (ship_x),
    .grant       (grant),
    .launch      (launch),
    .launch_slot (launch_slot),
    .launch_x    (launch_x),
    .launch_y    (launch_y),
    .launch_dir  (launch_dir)
  );

  always #5 frame_clk = ~frame_clk;

  int cyc = 0;
  always @(posedge frame_clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] grant;
    logic [1:0] slot;
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] dir;
  } exp_t;

  exp_t q[$];
  exp_t mon;
  int   checks = 0;
  int   errors = 0;
  int   exArr[NE];
  int   eyArr[NE];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [9:0] expY(input int y);
    int s;
    s = y + DY;
    return (s > 479) ? 10'd479 : 10'(s);
  endfunction

  // +1 = 2'b01, -1 = 2'b11.
  function automatic logic [1:0] expDir(input int sx, input int ex);
`ifdef FIRE_AIM_EN
    if (sx > ex + 8) return 2'b01;
    if (sx + 8 < ex) return 2'b11;
`endif
    return (sx < 0 || ex < 0) ? 2'b10 : 2'b00;
  endfunction

  task automatic applyPos();
    for (int i = 0; i < NE; i++) begin
      enemy_x[i*10 +: 10] = 10'(exArr[i]);
      enemy_y[i*10 +: 10] = 10'(eyArr[i]);
    end
  endtask

  task automatic push(input int c, input int w, input int slot);
    exp_t e;
    e.cyc   = c;
    e.grant = 8'(1 << w);
    e.slot  = 2'(slot);
    e.x     = 10'(exArr[w]);
    e.y     = expY(eyArr[w]);
    e.dir   = expDir(int'(ship_x), exArr[w]);
    q.push_back(e);
  endtask

  task automatic waitCyc(input int n);
    while (cyc < n) @(negedge frame_clk);
  endtask

  task automatic checkZero(input string tag);
    check({tag, "_grant"}, 32'(grant), 0);
    check({tag, "_launch"}, 32'(launch), 0);
    check({tag, "_slot"}, 32'(launch_slot), 0);
    check({tag, "_x"}, 32'(launch_x), 0);
    check({tag, "_y"}, 32'(launch_y), 0);
    check({tag, "_dir"}, 32'(launch_dir), 0);
  endtask

  // Monitor: compare each launch against the head of the expectation queue.
  always @(negedge frame_clk) begin
    if (Reset === 1'b1) begin
      if (launch === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_launch actual grant=%0h at cycle %0d required=no launch", grant, cyc);
        end else begin
          mon = q.pop_front();
          check("launch_cycle", 32'(cyc), 32'(mon.cyc));
          check("grant", 32'(grant), 32'(mon.grant));
          check("launch_slot", 32'(launch_slot), 32'(mon.slot));
          check("launch_x", 32'(launch_x), 32'(mon.x));
          check("launch_y", 32'(launch_y), 32'(mon.y));
          check("launch_dir", 32'(launch_dir), 32'(mon.dir));
        end
      end else begin
        check("idle_grant_dir", {22'd0, grant, launch_dir}, 0);
        if (q.size() > 0 && cyc > q[0].cyc) begin
          mon = q.pop_front();
          checks++;
          errors++;
          $display("FAIL missed_launch actual=none required grant=%0h at cycle %0d", mon.grant, mon.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  int k, p, qq, r, s, t;
  int shipVec[7] = '{200, 50, 105, 108, 109, 92, 91};

  initial begin
    // Reset with random inputs: every output must read zero.
    Reset       = 1'b0;
    game_active = 1'($urandom);
    fire_req    = 8'($urandom);
    enemy_alive = 8'($urandom);
    enemy_x     = 80'({$urandom(), $urandom(), $urandom()});
    enemy_y     = 80'({$urandom(), $urandom(), $urandom()});
    slot_busy   = 4'($urandom);
    ship_x      = 10'($urandom);
    repeat (3) @(negedge frame_clk);
    checkZero("reset");

    for (int i = 0; i < NE; i++) begin
      exArr[i] = 40 * i + 30;
      eyArr[i] = 50 * i + 10;
    end
    applyPos();
    game_active = 1'b1;
    fire_req    = 8'hFF;
    enemy_alive = 8'hFF;
    slot_busy   = 4'h0;
    ship_x      = 10'd0;
    @(negedge frame_clk);

    // Round-robin over all enemies: IDLE->ARB then launch, every CD+1 cycles.
    k = cyc;
    Reset = 1'b1;
    for (int n = 0; n < 9; n++) push(k + 2 + 5 * n, n % NE, 0);
    waitCyc(k + 42);
    fire_req = 8'h00;

    // Slot pick with saturated spawn Y; rr pointer sits at 1, only enemy 3 asks.
    waitCyc(k + 50);
    eyArr[3] = 470;
    applyPos();
    slot_busy = 4'b1011;
    fire_req  = 8'h08;
    push(k + 51, 3, 2);
    waitCyc(k + 51);
    fire_req  = 8'h00;
    slot_busy = 4'h0;

    // All slots busy for 20 cycles, then slot 1 frees: rr pointer 4 wins.
    p = k + 60;
    waitCyc(p);
    slot_busy = 4'hF;
    fire_req  = 8'hFF;
    waitCyc(p + 20);
    slot_busy = 4'b1101;
    push(p + 21, 4, 1);
    waitCyc(p + 21);
    fire_req  = 8'h00;
    slot_busy = 4'h0;

    // game_active drops mid-cooldown: no launch until it returns; rr kept.
    qq = p + 30;
    waitCyc(qq);
    fire_req = 8'hFF;
    push(qq + 1, 5, 0);
    waitCyc(qq + 2);
    game_active = 1'b0;
    waitCyc(qq + 12);
    game_active = 1'b1;
    r = qq + 12;
    push(r + 2, 6, 0);

    // Reset mid-cooldown: outputs clear immediately, rr pointer back to 0.
    waitCyc(r + 2);
    #1 Reset = 1'b0;
    #1 checkZero("rst_mid_cool");
    enemy_alive = 8'hFB;
    waitCyc(r + 5);
    s = r + 5;
    Reset = 1'b1;
    // Enemy 2 is dead: sequence skips it.
    push(s + 2, 0, 0);
    push(s + 7, 1, 0);
    push(s + 12, 3, 0);
    push(s + 17, 4, 0);
    waitCyc(s + 17);
    fire_req = 8'h04;

    // Single requester (enemy 0 at x=100) wins every CD+1 cycles; aim vectors.
    // With aiming: 200->+1, 50->-1, 105->0, 108->0, 109->+1, 92->0, 91->-1.
    t = s + 40;
    waitCyc(t);
    exArr[0]    = 100;
    applyPos();
    enemy_alive = 8'hFF;
    fire_req    = 8'h01;
    for (int n = 0; n < 7; n++) begin
      waitCyc(t + 5 * n);
      ship_x = 10'(shipVec[n]);
      push(t + 5 * n + 1, 0, 0);
    end
    waitCyc(t + 31);
    fire_req = 8'h00;
    waitCyc(t + 40);

    check("queue_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/enemy_fire_scheduler.md
Name: enemy_fire_scheduler

Overview:
- Decides which enemy fires next and which shared enemy-projectile slot the shot occupies.
- Arbitrates NE enemy fire requests into NP projectile slots using round-robin, with a global inter-shot cooldown.
- Advances once per frame_clk tick and issues one-cycle launch commands to the enemy projectile datapath.
- Sits beside the ship controller and uses the same frame-rate clock.

Parameters:
- NE, 8, number of enemies (requesters).
- NP, 4, number of enemy projectile slots.
- COOLDOWN, 16, minimum frames between consecutive launches; legal range 1..255.
- SPAWN_DY, 12, vertical offset from enemy origin to projectile spawn point, in pixels.

Ports:
- frame_clk  in  1  frame-rate clock.
- Reset  in  1  asynchronous, active-low reset.
- game_active  in  1  high while enemies may fire.
- fire_req  in  NE  level request per enemy; bit i means enemy i wants to fire.
- enemy_alive  in  NE  enemy i is eligible only when alive.
- enemy_x  in  NE*10  packed X origins; enemy i uses bits [10i+9:10i].
- enemy_y  in  NE*10  packed Y origins, same packing as enemy_x.
- slot_busy  in  NP  slot j already has a projectile in flight.
- ship_x  in  10  ship X position (used only with FIRE_AIM_EN).
- grant  out  NE  one-hot, one-cycle pulse naming the enemy that fired.
- launch  out  1  one-cycle launch strobe.
- launch_slot  out  $clog2(NP)  slot index to load.
- launch_x  out  10  spawn X.
- launch_y  out  10  spawn Y.
- launch_dir  out  2  signed horizontal step: -1, 0 or +1.

Behaviour:
- All outputs are registered.
- Reset asserted (low), at any time including mid-cooldown:
  - state=IDLE, rr_ptr=0, cooldown=0.
  - grant=0, launch=0, launch_slot=0, launch_x=0, launch_y=0, launch_dir=0.
- Eligible set: elig = fire_req & enemy_alive.
- FSM states and transitions:
  - IDLE: if game_active=1, go to ARB next cycle. No launches from IDLE.
  - ARB: fires when |elig and at least one slot_busy bit is 0. Otherwise stay in ARB; rr_ptr is unchanged.
  - COOL: cooldown decrements by 1 each cycle. When cooldown==1, go to ARB.
- Fire decision in ARB:
  - Winner w = first set bit of elig scanning rr_ptr, rr_ptr+1, … with modulo-NE wrap.
  - Slot s = lowest-index j with slot_busy[j]=0.
  - Next cycle: launch=1, grant=1<<w, launch_slot=s, launch_x=enemy_x[w].
  - launch_y = min(enemy_y[w]+SPAWN_DY, 479), computed in 11 bits, then saturated.
  - Same cycle: rr_ptr = (w+1) mod NE, cooldown = COOLDOWN, state = COOL.
- Latency: inputs sampled on cycle t produce launch on cycle t+1.
- Spacing: launches are separated by exactly COOLDOWN+1 cycles when requests are continuous. With COOLDOWN=1, a launch occurs every 2 frames.
- launch, grant and launch_dir return to 0 the cycle after a launch. launch_slot, launch_x and launch_y hold their last values.
- game_active dropping in any state: go to IDLE next cycle, clear cooldown, keep rr_ptr, drive no launch.
- Boundary conditions:
  - A request deasserted in the same cycle as arbitration is simply not considered.
  - All slots busy: no grant.
  - A single eligible enemy wins repeatedly, once per cooldown period.
  - slot_busy is sampled as-is. The scheduler does not track its own launches, so the datapath must raise slot_busy[s] within COOLDOWN cycles.

Optional Feature:
- Macro: FIRE_AIM_EN.
- Defined: launch_dir = +1 if ship_x > enemy_x[w]+8; -1 if ship_x+8 < enemy_x[w]; else 0. Compare in 11 bits; registered together with launch.
- Undefined: launch_dir is constant 0 and ship_x is ignored; the port remains present.

Decomposition:
- Shared package galaga_lib holds:
  - NE_DEFAULT, NP_E_DEFAULT, SCREEN_H_MAX=479.
  - FSM enum fire_state_t {IDLE, ARB, COOL}.
  - Function rr_pick(req, ptr) returning the winner index.
- One sub-module: rr_arbiter_ne, the combinational rotate/priority-encode/unrotate that produces the winner index and a valid flag.
- Slot selection is an inline priority encoder.

Test Plan:
1. Reset low with random inputs -> all outputs 0. Release Reset with game_active=1 -> state ARB on the next edge.
2. Round-robin: fire_req=8'hFF, enemy_alive=8'hFF, slot_busy=0, COOLDOWN=4 -> grant sequence 01,02,04,…,80,01. Launches every 5 cycles; launch_slot=0 each time.
3. Slot pick: slot_busy=4'b1011, one request from enemy 3 with enemy_y=470 -> launch_slot=2, launch_y=479 (saturated), launch_x equals enemy_x[3].
4. All slots busy: slot_busy=4'hF with requests pending for 20 cycles -> no launch. Clear slot_busy[1] -> launch_slot=1 one cycle later, granted enemy = rr_ptr winner.
5. Interrupts: game_active drops mid-COOL -> IDLE, no launch. Reset asserted mid-COOL -> immediate zeros. Dead enemy (enemy_alive[2]=0, fire_req[2]=1) -> never granted.
6. FIRE_AIM_EN defined, enemy_x=100: ship_x=200 -> launch_dir=+1; ship_x=50 -> -1; ship_x=105 -> 0. Macro undefined -> launch_dir always 0.
